// File: rtl/seq_pattern_bank_editor_if.sv
// Panel/playback bus of the multi-bank step pattern editor.
// master = front panel + playback engine, slave = the editor.
interface seq_pattern_bank_editor_if #(
  parameter int STEPS  = 16,
  parameter int TRACKS = 4,
  parameter int BANKS  = 4
);
  localparam int SW = $clog2(STEPS);
  localparam int BW = $clog2(BANKS);

  logic [1:0]        mode;
  logic [BW-1:0]     edit_bank;
  logic [SW-1:0]     edit_step;
  logic [TRACKS-1:0] tgl_track;
  logic              clr_req;
  logic              copy_req;
  logic [BW-1:0]     copy_src;
  logic [BW-1:0]     play_bank;
  logic [SW-1:0]     play_step;
  logic [TRACKS-1:0] play_pattern;
  logic [TRACKS-1:0] edit_row;
  logic              busy;

  modport master (
    output mode, edit_bank, edit_step, tgl_track, clr_req, copy_req, copy_src,
           play_bank, play_step,
    input  play_pattern, edit_row, busy
  );

  modport slave (
    input  mode, edit_bank, edit_step, tgl_track, clr_req, copy_req, copy_src,
           play_bank, play_step,
    output play_pattern, edit_row, busy
  );
endinterface

// File: rtl/seq_pattern_bank_editor.sv
// BANKS x STEPS x TRACKS flop pattern store with edge-detected toggle edits and
// a clear sweep; the bank-copy sweep is built only with SEQ_BANK_COPY_EN defined.
module seq_pattern_bank_editor #(
  parameter int STEPS  = 16,
  parameter int TRACKS = 4,
  parameter int BANKS  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  seq_pattern_bank_editor_if.slave    bus
);
  localparam int SW = $clog2(STEPS);
  localparam int BW = $clog2(BANKS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
`ifdef SEQ_BANK_COPY_EN
  localparam logic [1:0] S_COPY  = 2'd2;
`endif
  localparam logic [SW-1:0] IDX_LAST = SW'(STEPS - 1);

  logic [BANKS-1:0][STEPS-1:0][TRACKS-1:0] mem_q, mem_d;
  logic [TRACKS-1:0] tgl_q, tgl_d;
  logic [TRACKS-1:0] play_q, play_d;
  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     dst_q, dst_d;
  logic [TRACKS-1:0] rise;

`ifdef SEQ_BANK_COPY_EN
  logic [BW-1:0]     src_q, src_d;
`else
  logic              unused_copy;
  assign unused_copy = bus.copy_req ^ (^bus.copy_src);
`endif

  assign rise = bus.tgl_track & ~tgl_q;

  always_comb begin
    mem_d   = mem_q;
    state_d = state_q;
    idx_d   = idx_q;
    dst_d   = dst_q;
`ifdef SEQ_BANK_COPY_EN
    src_d   = src_q;
`endif
    // edge detector keeps tracking even while busy, so rises during a sweep are lost
    tgl_d   = bus.tgl_track;
    play_d  = mem_q[bus.play_bank][bus.play_step];

    case (state_q)
      S_IDLE: begin
        if (bus.mode == 2'd0)
          mem_d[bus.edit_bank][bus.edit_step] = mem_q[bus.edit_bank][bus.edit_step] ^ rise;
        // clear has priority over a simultaneous copy
        if (bus.clr_req) begin
          state_d = S_CLEAR;
          dst_d   = bus.edit_bank;
          idx_d   = '0;
        end
`ifdef SEQ_BANK_COPY_EN
        else if (bus.copy_req) begin
          state_d = S_COPY;
          dst_d   = bus.edit_bank;
          src_d   = bus.copy_src;
          idx_d   = '0;
        end
`endif
      end
      S_CLEAR: begin
        mem_d[dst_q][idx_q] = '0;
        idx_d = idx_q + SW'(1);
        if (idx_q == IDX_LAST) state_d = S_IDLE;
      end
`ifdef SEQ_BANK_COPY_EN
      S_COPY: begin
        mem_d[dst_q][idx_q] = mem_q[src_q][idx_q];
        idx_d = idx_q + SW'(1);
        if (idx_q == IDX_LAST) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      tgl_q   <= '0;
      play_q  <= '0;
      state_q <= S_IDLE;
      idx_q   <= '0;
      dst_q   <= '0;
`ifdef SEQ_BANK_COPY_EN
      src_q   <= '0;
`endif
    end else begin
      mem_q   <= mem_d;
      tgl_q   <= tgl_d;
      play_q  <= play_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      dst_q   <= dst_d;
`ifdef SEQ_BANK_COPY_EN
      src_q   <= src_d;
`endif
    end
  end

  assign bus.play_pattern = play_q;
  assign bus.edit_row     = mem_q[bus.edit_bank][bus.edit_step];
  assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_seq_pattern_bank_editor.sv
// Directed bench for seq_pattern_bank_editor (default 16 steps, 4 tracks, 4 banks).
module tb_seq_pattern_bank_editor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cnt;

  seq_pattern_bank_editor_if #(.STEPS(16), .TRACKS(4), .BANKS(4)) bus_if ();

  seq_pattern_bank_editor #(.STEPS(16), .TRACKS(4), .BANKS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // combinational peek through edit_row
  task automatic row(input string tag, input int b, input int s, input logic [3:0] exp);
    bus_if.edit_bank = 2'(b);
    bus_if.edit_step = 4'(s);
    #1;
    chk(tag, 32'(bus_if.edit_row), 32'(exp));
  endtask

  task automatic pulse(input int b, input int s, input logic [3:0] t);
    bus_if.edit_bank = 2'(b);
    bus_if.edit_step = 4'(s);
    bus_if.tgl_track = t;
    tick();
    bus_if.tgl_track = '0;
    tick();
  endtask

  initial begin
    bus_if.mode = 2'd0;      bus_if.edit_bank = '0; bus_if.edit_step = '0;
    bus_if.tgl_track = '0;   bus_if.clr_req = 1'b0; bus_if.copy_req = 1'b0;
    bus_if.copy_src = '0;    bus_if.play_bank = '0; bus_if.play_step = '0;

    tick(); tick();
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_play", 32'(bus_if.play_pattern), 32'd0);
    chk("rst_row",  32'(bus_if.edit_row), 32'd0);
    rst_n = 1'b1;
    tick();

    // held level toggles once
    bus_if.edit_bank = 2'd1; bus_if.edit_step = 4'd3;
    bus_if.tgl_track = 4'b0101;
    repeat (5) tick();
    chk("hold_once", 32'(bus_if.edit_row), 32'h5);
    bus_if.tgl_track = '0;
    tick();
    pulse(1, 3, 4'b0001);
    chk("repulse", 32'(bus_if.edit_row), 32'h4);
    bus_if.play_bank = 2'd1; bus_if.play_step = 4'd3;
    tick();
    chk("play_rd", 32'(bus_if.play_pattern), 32'h4);

    // play mode blocks edits
    bus_if.mode = 2'd1;
    pulse(1, 3, 4'b1111);
    chk("mode1_row",  32'(bus_if.edit_row), 32'h4);
    chk("mode1_play", 32'(bus_if.play_pattern), 32'h4);
    row("mode1_other", 0, 0, 4'h0);
    bus_if.mode = 2'd0;

    // fill bank 2, plus markers in banks 0 and 3
    for (int s = 0; s < 16; s++) pulse(2, s, 4'b1001);
    pulse(0, 5, 4'b1010);
    pulse(3, 0, 4'b0011);
    row("fill_b2s7", 2, 7, 4'h9);

    // clear bank 2, toggle into bank 1 mid-sweep must be discarded
    bus_if.edit_bank = 2'd2;
    bus_if.clr_req = 1'b1;
    tick();
    bus_if.clr_req = 1'b0;
    cnt = 0;
    while (bus_if.busy && cnt < 40) begin
      cnt++;
      if (cnt == 3) begin
        bus_if.edit_bank = 2'd1; bus_if.edit_step = 4'd3; bus_if.tgl_track = 4'b1111;
      end
      if (cnt == 5) bus_if.tgl_track = '0;
      tick();
    end
    chk("clr_busy_len", 32'(cnt), 32'd16);
    for (int s = 0; s < 16; s++) row("clr_b2_zero", 2, s, 4'h0);
    row("clr_b1_keep", 1, 3, 4'h4);
    row("clr_b0_keep", 0, 5, 4'hA);
    row("clr_b3_keep", 3, 0, 4'h3);
    pulse(1, 3, 4'b0010);
    chk("edit_after_clr", 32'(bus_if.edit_row), 32'h6);

`ifdef SEQ_BANK_COPY_EN
    bus_if.copy_src = 2'd0; bus_if.edit_bank = 2'd3;
    bus_if.copy_req = 1'b1;
    tick();
    bus_if.copy_req = 1'b0;
    bus_if.copy_src = 2'd1;
    cnt = 0;
    while (bus_if.busy && cnt < 40) begin cnt++; tick(); end
    chk("copy_busy_len", 32'(cnt), 32'd16);
    row("copy_s5", 3, 5, 4'hA);
    row("copy_s0", 3, 0, 4'h0);
    pulse(3, 1, 4'b0100);
    bus_if.edit_bank = 2'd3;
    bus_if.clr_req = 1'b1; bus_if.copy_req = 1'b1;
    tick();
    bus_if.clr_req = 1'b0; bus_if.copy_req = 1'b0;
    cnt = 0;
    while (bus_if.busy && cnt < 40) begin cnt++; tick(); end
    chk("both_busy_len", 32'(cnt), 32'd16);
    row("both_s5", 3, 5, 4'h0);
    row("both_s1", 3, 1, 4'h0);
`else
    bus_if.copy_src = 2'd0; bus_if.edit_bank = 2'd3;
    bus_if.copy_req = 1'b1;
    tick();
    chk("nocopy_busy", 32'(bus_if.busy), 32'd0);
    bus_if.copy_req = 1'b0;
    repeat (17) tick();
    row("nocopy_s0", 3, 0, 4'h3);
    row("nocopy_s5", 3, 5, 4'h0);
`endif

    // reset mid-sweep
    bus_if.edit_bank = 2'd1;
    bus_if.clr_req = 1'b1;
    tick();
    bus_if.clr_req = 1'b0;
    repeat (6) tick();
    chk("mid_busy", 32'(bus_if.busy), 32'd1);
    bus_if.edit_bank = 2'd0; bus_if.edit_step = 4'd5;
    bus_if.play_bank = 2'd0; bus_if.play_step = 4'd5;
    tick();
    chk("pre_rst_play", 32'(bus_if.play_pattern), 32'hA);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus_if.busy), 32'd0);
    chk("arst_play", 32'(bus_if.play_pattern), 32'd0);
    chk("arst_row",  32'(bus_if.edit_row), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse(0, 5, 4'b0110);
    chk("post_rst_edit", 32'(bus_if.edit_row), 32'h6);
    chk("post_rst_busy", 32'(bus_if.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
